// File: rtl/tdm_demux_4ch_if.sv
// Purpose: serial-side and parallel-side signals of the 4-channel TDM demultiplexer.
// Latency: none, this is wiring only.
// Backpressure: none; en is a strobe from the sender and nothing flows back upstream.
// Ports: en/sync/din come from the sender (master).
//        Y/slot/frame_valid/locked/sync_err are driven by the demux (slave).
interface tdm_demux_4ch_if;
   logic       en;
   logic       sync;
   logic       din;
   logic [3:0] Y;
   logic [1:0] slot;
   logic       frame_valid;
   logic       locked;
   logic       sync_err;

   modport master (
      output en, sync, din,
      input  Y, slot, frame_valid, locked, sync_err
   );

   modport slave (
      input  en, sync, din,
      output Y, slot, frame_valid, locked, sync_err
   );
endinterface

// File: rtl/tdm_demux_4ch.sv
// Purpose: rebuilds four 1-bit channels from a 4:1 TDM serial stream that carries a slot-0 sync marker.
// Latency: Y and frame_valid update on the edge that captures slot 3, so they are visible one cycle later.
// Backpressure: none; en=0 freezes all framing state, and the frame_valid/sync_err pulses still clear.
// Ports: clk, rst_n (async, active low), and bus (slave modport).
//        Inputs on bus: en, sync, din.
//        Outputs on bus: Y, slot, frame_valid, locked, sync_err.
module tdm_demux_4ch (
   input  logic           clk,
   input  logic           rst_n,
   tdm_demux_4ch_if.slave bus
);

   typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [2:0] shadow_q, shadow_d;   // slot 0..2 samples of the frame in progress
   logic [3:0] y_q, y_d;
   logic [1:0] slot_q, slot_d;
   logic       fv_q, fv_d;
   logic       err_q, err_d;
   logic       miss_q, miss_d;       // one missed sync already seen; a second one drops lock

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         shadow_q <= 3'b000;
         y_q      <= 4'b0000;
         slot_q   <= 2'b00;
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
         miss_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         y_q      <= y_d;
         slot_q   <= slot_d;
         fv_q     <= fv_d;
         err_q    <= err_d;
         miss_q   <= miss_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      y_d      = y_q;
      slot_d   = slot_q;
      miss_d   = miss_q;
      fv_d     = 1'b0;
      err_d    = 1'b0;

      if (bus.en) begin
         unique case (state_q)
            HUNT: begin
               if (bus.sync) begin
                  shadow_d[0] = bus.din;
                  slot_d      = 2'd1;
                  miss_d      = 1'b0;
                  state_d     = LOCK;
               end
            end

            LOCK: begin
               if (bus.sync) begin
                  // A sync in slot 0 is the normal case.
                  // A sync in any other slot abandons the partial frame and restarts at slot 0.
                  if (slot_q != 2'd0) begin
                     err_d = 1'b1;
                  end
                  shadow_d[0] = bus.din;
                  slot_d      = 2'd1;
                  miss_d      = 1'b0;
               end else begin
                  unique case (slot_q)
                     2'd0: begin
                        if (miss_q) begin
                           // Second consecutive missed sync: drop lock and discard this sample.
                           state_d = HUNT;
                           slot_d  = 2'd0;
                           miss_d  = 1'b0;
                        end else begin
                           // Coast through one missed sync on the assumption that framing still holds.
                           shadow_d[0] = bus.din;
                           slot_d      = 2'd1;
                           miss_d      = 1'b1;
                        end
                     end
                     2'd1: begin
                        shadow_d[1] = bus.din;
                        slot_d      = 2'd2;
                     end
                     2'd2: begin
                        shadow_d[2] = bus.din;
                        slot_d      = 2'd3;
                     end
                     2'd3: begin
                        y_d    = {bus.din, shadow_q[2], shadow_q[1], shadow_q[0]};
                        fv_d   = 1'b1;
                        slot_d = 2'd0;
                     end
                     default: ;
                  endcase
               end
            end

            default: state_d = HUNT;
         endcase
      end
   end

   // Outputs (all come straight from registers)
   always_comb begin
      bus.Y           = y_q;
      bus.slot        = slot_q;
      bus.frame_valid = fv_q;
      bus.locked      = (state_q == LOCK);
      bus.sync_err    = err_q;
   end

endmodule
